// File: rtl/branch_unit.sv
// LC-3 control-transfer resolver: evaluates BR/JMP/JSR/JSRR against latched n/z/p
// and issues one-cycle PC load and R7 link write enables.
//
// state  | meaning
// IDLE   | waiting for start_i; latches IR/PC/nzp on accept
// DECODE | sr1_sel_o driven from IR; base register sampled at exit
// EVAL   | taken/target/link computed; results registered at exit
// COMMIT | done_o, ld_pc_o, ld_r7_o pulse for one cycle
module branch_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [15:0] ir_i,
    input  logic [15:0] pc_i,
    input  logic        n_i,
    input  logic        z_i,
    input  logic        p_i,
    input  logic [15:0] base_r_i,
    output logic [2:0]  sr1_sel_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        taken_o,
    output logic        illegal_o,
    output logic [15:0] pc_next_o,
    output logic        ld_pc_o,
    output logic        ld_r7_o,
    output logic [15:0] r7_data_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EVAL   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    state_t      state_q;
    logic [15:0] ir_q;
    logic [15:0] pc_q;
    logic        n_q;
    logic        z_q;
    logic        p_q;
    logic [15:0] base_r_q;
    logic [2:0]  sr1_sel_q;
    logic        busy_q;
    logic        done_q;
    logic        taken_q;
    logic        illegal_q;
    logic [15:0] pc_next_q;
    logic        ld_pc_q;
    logic        ld_r7_q;
    logic [15:0] r7_data_q;

    logic        taken_d;
    logic        illegal_d;
    logic        link_d;
    logic [15:0] target_d;
    logic [15:0] pc_next_d;

    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        link_d    = 1'b0;
        target_d  = pc_q;
        case (ir_q[15:12])
            OP_BR: begin
                taken_d  = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q);
                target_d = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
            end
            OP_JMP: begin
                taken_d  = 1'b1;
                target_d = base_r_q;
            end
            OP_JSR: begin
                taken_d  = 1'b1;
                link_d   = 1'b1;
                target_d = ir_q[11] ? (pc_q + {{5{ir_q[10]}}, ir_q[10:0]}) : base_r_q;
            end
            default: illegal_d = 1'b1;
        endcase
        pc_next_d = taken_d ? target_d : pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            pc_q      <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            p_q       <= 1'b0;
            base_r_q  <= '0;
            sr1_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_next_q <= '0;
            ld_pc_q   <= 1'b0;
            ld_r7_q   <= 1'b0;
            r7_data_q <= '0;
        end else begin
            done_q  <= 1'b0;
            ld_pc_q <= 1'b0;
            ld_r7_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        ir_q      <= ir_i;
                        pc_q      <= pc_i;
                        n_q       <= n_i;
                        z_q       <= z_i;
                        p_q       <= p_i;
                        sr1_sel_q <= ir_i[8:6];
                        busy_q    <= 1'b1;
                        state_q   <= S_DECODE;
                    end
                end
                // BaseR sampled here so a JSRR through R7 sees the pre-link value
                S_DECODE: begin
                    base_r_q <= base_r_i;
                    state_q  <= S_EVAL;
                end
                S_EVAL: begin
                    pc_next_q <= pc_next_d;
                    r7_data_q <= pc_q;
                    taken_q   <= taken_d;
                    illegal_q <= illegal_d;
                    done_q    <= 1'b1;
                    ld_pc_q   <= taken_d;
                    ld_r7_q   <= link_d;
                    state_q   <= S_COMMIT;
                end
                S_COMMIT: begin
                    busy_q    <= 1'b0;
                    sr1_sel_q <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sr1_sel_o = sr1_sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign taken_o   = taken_q;
    assign illegal_o = illegal_q;
    assign pc_next_o = pc_next_q;
    assign ld_pc_o   = ld_pc_q;
    assign ld_r7_o   = ld_r7_q;
    assign r7_data_o = r7_data_q;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vector table, hand sequences for handshake/reset,
// and random instructions against an arithmetic reference model.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        n, z, p;
    logic [15:0] base_r;
    logic [2:0]  sr1_sel;
    logic        busy, done, taken, illegal, ld_pc, ld_r7;
    logic [15:0] pc_next, r7_data;

    int checks = 0;
    int errors = 0;

    branch_unit dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .ir_i      (ir),
        .pc_i      (pc),
        .n_i       (n),
        .z_i       (z),
        .p_i       (p),
        .base_r_i  (base_r),
        .sr1_sel_o (sr1_sel),
        .busy_o    (busy),
        .done_o    (done),
        .taken_o   (taken),
        .illegal_o (illegal),
        .pc_next_o (pc_next),
        .ld_pc_o   (ld_pc),
        .ld_r7_o   (ld_r7),
        .r7_data_o (r7_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [2:0]  nzp;
        logic [15:0] baser;
        logic [15:0] baser_late;
        logic        e_taken;
        logic        e_ill;
        logic        e_link;
        logic [15:0] e_pc_next;
        logic [15:0] e_r7;
        logic [2:0]  e_sr1;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: decode straight from the ISA definition using signed integer offsets.
    task automatic model(input logic [15:0] i_ir, input logic [15:0] i_pc, input logic [2:0] i_nzp,
                         input logic [15:0] i_base, output logic o_t, output logic o_il,
                         output logic o_lk, output logic [15:0] o_next);
        int off;
        int tgt;
        o_t = 0; o_il = 0; o_lk = 0; tgt = int'(i_pc);
        if (i_ir[15:12] == 4'd0) begin
            off = int'(i_ir[8:0]);
            if (off >= 256) off -= 512;
            tgt = int'(i_pc) + off;
            o_t = ((i_ir[11] && i_nzp[2]) || (i_ir[10] && i_nzp[1]) || (i_ir[9] && i_nzp[0]));
        end else if (i_ir[15:12] == 4'd12) begin
            o_t = 1; tgt = int'(i_base);
        end else if (i_ir[15:12] == 4'd4) begin
            o_t = 1; o_lk = 1;
            if (i_ir[11]) begin
                off = int'(i_ir[10:0]);
                if (off >= 1024) off -= 2048;
                tgt = int'(i_pc) + off;
            end else begin
                tgt = int'(i_base);
            end
        end else begin
            o_il = 1;
        end
        if (!o_t) tgt = int'(i_pc);
        o_next = 16'(tgt & 32'hFFFF);
    endtask

    // Starts at a negedge in IDLE, ends at the negedge of cycle 4 (back in IDLE).
    task automatic run_op(input string tag, input vec_t v, input bit poke_start);
        start = 1'b1; ir = v.ir; pc = v.pc; {n, z, p} = v.nzp; base_r = 16'($urandom);
        @(posedge clk); @(negedge clk);
        start = 1'b0; ir = 16'($urandom); pc = 16'($urandom); {n, z, p} = 3'($urandom);
        base_r = v.baser;
        chk({tag, " c1 busy"}, busy, 1);
        chk({tag, " c1 sr1"}, sr1_sel, v.e_sr1);
        chk({tag, " c1 done"}, done, 0);
        @(posedge clk); @(negedge clk);
        base_r = v.baser_late;
        if (poke_start) start = 1'b1;
        chk({tag, " c2 done"}, done, 0);
        chk({tag, " c2 sr1"}, sr1_sel, v.e_sr1);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk({tag, " c3 done"}, done, 1);
        chk({tag, " c3 busy"}, busy, 1);
        chk({tag, " c3 sr1"}, sr1_sel, v.e_sr1);
        chk({tag, " c3 taken"}, taken, v.e_taken);
        chk({tag, " c3 illegal"}, illegal, v.e_ill);
        chk({tag, " c3 ld_pc"}, ld_pc, v.e_taken);
        chk({tag, " c3 ld_r7"}, ld_r7, v.e_link);
        chk({tag, " c3 pc_next"}, pc_next, v.e_pc_next);
        chk({tag, " c3 r7_data"}, r7_data, v.e_r7);
        @(posedge clk); @(negedge clk);
        chk({tag, " c4 done"}, done, 0);
        chk({tag, " c4 ld_pc"}, ld_pc, 0);
        chk({tag, " c4 ld_r7"}, ld_r7, 0);
        chk({tag, " c4 busy"}, busy, 0);
        chk({tag, " c4 pc_next hold"}, pc_next, v.e_pc_next);
        chk({tag, " c4 taken hold"}, taken, v.e_taken);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " sr1"}, sr1_sel, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " taken"}, taken, 0);
        chk({tag, " illegal"}, illegal, 0);
        chk({tag, " ld_pc"}, ld_pc, 0);
        chk({tag, " ld_r7"}, ld_r7, 0);
        chk({tag, " pc_next"}, pc_next, 0);
        chk({tag, " r7_data"}, r7_data, 0);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        int   dones;
        int   first_done;
        int   pulses;
        int   sel;

        //            ir       pc       nzp   baser    late     t  il lk next     r7       sr1
        vecs[0] = '{16'h0405, 16'h3001, 3'b010, 16'h0000, 16'h0000, 1, 0, 0, 16'h3006, 16'h3001, 3'd0};
        vecs[1] = '{16'h09FF, 16'h3000, 3'b001, 16'h0000, 16'h0000, 0, 0, 0, 16'h3000, 16'h3000, 3'd7};
        vecs[2] = '{16'h4FFF, 16'h0000, 3'b000, 16'h5555, 16'h5555, 1, 0, 1, 16'hFFFF, 16'h0000, 3'd7};
        vecs[3] = '{16'h41C0, 16'h3005, 3'b100, 16'h1234, 16'hBEEF, 1, 0, 1, 16'h1234, 16'h3005, 3'd7};
        vecs[4] = '{16'h1021, 16'h3000, 3'b111, 16'h0000, 16'h0000, 0, 1, 0, 16'h3000, 16'h3000, 3'd0};
        vecs[5] = '{16'hC080, 16'h3000, 3'b000, 16'hABCD, 16'h1111, 1, 0, 0, 16'hABCD, 16'h3000, 3'd2};
        vecs[6] = '{16'h0E02, 16'h4000, 3'b010, 16'h0000, 16'h0000, 1, 0, 0, 16'h4002, 16'h4000, 3'd0};
        vecs[7] = '{16'h0005, 16'h2000, 3'b111, 16'h0000, 16'h0000, 0, 0, 0, 16'h2000, 16'h2000, 3'd0};
        vecs[8] = '{16'h03FE, 16'h3000, 3'b001, 16'h0000, 16'h0000, 1, 0, 0, 16'h2FFE, 16'h3000, 3'd7};

        rst_n = 1'b0; start = 1'b0; ir = '0; pc = '0; {n, z, p} = 3'b000; base_r = '0;
        #1;
        chk_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], (i == 4));
        end

        // Start held high: one accept per return to IDLE.
        start = 1'b1; ir = 16'h0E02; pc = 16'h1000; {n, z, p} = 3'b001;
        dones = 0; first_done = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                dones++;
                if (first_done == 0) first_done = c;
            end
        end
        start = 1'b0;
        chk("b2b done count", 16'(dones), 16'd3);
        chk("b2b first done cycle", 16'(first_done), 16'd3);
        chk("b2b busy at idle", busy, 0);
        @(posedge clk); @(negedge clk);
        chk("b2b no extra accept", busy, 0);

        // Reset during EVAL of a JMP.
        start = 1'b1; ir = 16'hC1C0; pc = 16'h3000; base_r = 16'h7777;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst in eval busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (ld_pc || ld_r7 || done) pulses++;
        end
        chk("midrst no pulses", 16'(pulses), 16'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post-rst brnzp", vecs[6], 1'b0);

        // Randomised instructions against the reference model.
        for (int k = 0; k < 40; k++) begin
            v.ir = 16'($urandom);
            sel = $urandom_range(0, 5);
            if (sel <= 1) v.ir[15:12] = 4'h0;
            else if (sel == 2) v.ir[15:12] = 4'hC;
            else if (sel <= 4) v.ir[15:12] = 4'h4;
            v.pc = 16'($urandom);
            v.nzp = 3'($urandom);
            v.baser = 16'($urandom);
            v.baser_late = 16'($urandom);
            model(v.ir, v.pc, v.nzp, v.baser, v.e_taken, v.e_ill, v.e_link, v.e_pc_next);
            v.e_r7 = v.pc;
            v.e_sr1 = v.ir[8:6];
            run_op($sformatf("rnd%0d ir=%h", k, v.ir), v, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Multi-cycle control-transfer resolver for the LC-3 datapath and the consumer of the condition codes written by the CC register. It accepts a BR, JMP/RET or JSR/JSRR instruction with a handshake, evaluates the branch condition against n/z/p, and computes the target address. It then issues the PC load and R7 linkage write. It sits between the control FSM (Start/Done) and the PC/register-file load enables.

## Interface
- No parameters; all datapaths are 16 bits, fixed by the ISA.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- IR  in  16  instruction word.
- PC  in  16  already-incremented PC.
- n, z, p  in  1 each  current condition codes.
- BaseR  in  16  register-file SR1 read data, addressed by SR1_sel.
- SR1_sel  out  3  base-register index for the register file.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Taken  out  1  control transfer occurs; valid while Done=1.
- Illegal  out  1  opcode not BR/JMP/JSR; valid while Done=1.
- PC_next  out  16  registered target, or the latched PC if not taken.
- LD_PC  out  1  one-cycle PC load enable.
- LD_R7  out  1  one-cycle R7 write enable.
- R7_data  out  16  link value, the latched PC.

## Operation
- States: IDLE → DECODE → EVAL → COMMIT → IDLE. No other transitions; no stalls.
- IDLE:
  - Start=1 at a rising edge latches IR_q, PC_q, n_q, z_q, p_q and moves to DECODE.
  - Start=0 stays in IDLE.
- DECODE: SR1_sel = IR_q[8:6]. This value is held from DECODE through COMMIT. BaseR is captured into BaseR_q at the DECODE→EVAL edge.
- EVAL: combinationally computes taken, target and link by opcode IR_q[15:12]:
  - 0000 BR:
    - taken = (IR_q[11]&n_q) | (IR_q[10]&z_q) | (IR_q[9]&p_q).
    - target = PC_q + SEXT(IR_q[8:0]).
    - nzp=000 is never taken.
  - 1100 JMP/RET: taken=1, target=BaseR_q.
  - 0100 with IR_q[11]=1 (JSR): taken=1, target = PC_q + SEXT(IR_q[10:0]), link=1.
  - 0100 with IR_q[11]=0 (JSRR): taken=1, target=BaseR_q, link=1.
  - Any other opcode: illegal=1, taken=0, link=0.
- EVAL→COMMIT edge registers:
  - PC_next = target if taken, else PC_q.
  - R7_data = PC_q.
  - The Taken, Illegal and link flags.
- COMMIT:
  - Done=1.
  - LD_PC = Taken.
  - LD_R7 = link.
  - Returns to IDLE unconditionally.
- Arithmetic: 16-bit two's complement, wraps modulo 2^16, no overflow flag.
- JSRR with base R7: the target is the old R7, because BaseR_q is captured before the LD_R7 write. R7_data is the link PC.
- Start while Busy=1 is ignored, not queued. Start held high continuously yields back-to-back operations, one accept per return to IDLE.
- Inputs changing after the accept edge have no effect, except BaseR, which is sampled only at the DECODE→EVAL edge.

## Timing
- Accept edge T0; DECODE in cycle 1; EVAL in cycle 2; Done/LD_PC/LD_R7 high for exactly cycle 3. IDLE resumes in cycle 4.
- Throughput: one instruction per 4 cycles.
- Reset (Reset=0) takes effect immediately, independent of Clk:
  - State goes to IDLE.
  - SR1_sel, Busy, Done, Taken, Illegal, LD_PC and LD_R7 go to 0.
  - PC_next and R7_data go to 0x0000.
- Reset mid-operation discards the instruction. No LD_PC or LD_R7 pulse may follow the reset release.
- The first Start is accepted on the first rising edge after Reset deasserts.
- PC_next, R7_data, Taken and Illegal hold their values after COMMIT until the next COMMIT or reset.
- Done, LD_PC and LD_R7 are never high outside COMMIT.

## Test plan
- BRz taken: IR=0x0405, z=1, PC=0x3001 → cycle 3: Done=1, Taken=1, LD_PC=1, PC_next=0x3006, LD_R7=0.
- BRn not taken: IR=0x09FF, n=0, p=1, PC=0x3000 → Done=1, Taken=0, LD_PC=0, PC_next=0x3000.
- JSR wrap: IR=0x4FFF, PC=0x0000 → PC_next=0xFFFF, LD_PC=1, LD_R7=1, R7_data=0x0000.
- JSRR via R7:
  - Stimulus: IR=0x41C0, PC=0x3005, BaseR=0x1234 presented in DECODE.
  - Response: SR1_sel=7 from cycle 1, PC_next=0x1234, R7_data=0x3005.
  - BaseR changed to 0xBEEF in cycle 2 must not alter PC_next.
- Illegal/handshake:
  - IR=0x1021 → Done=1, Illegal=1, LD_PC=0, LD_R7=0.
  - A second Start pulsed in cycle 2 is ignored; only one Done pulse occurs.
- Reset mid-op: assert Reset=0 during EVAL of a JMP → all outputs 0 immediately, no LD_PC pulse afterward. After release, Start with BRnzp IR=0x0E02, PC=0x4000 gives PC_next=0x4002.
